// File: rtl/axi_write_burst_multi_if.sv
// AXI4 write-channel bundle (AW, W, B) used by axi_write_burst_multi.
interface axi_write_burst_multi_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [2:0]        awprot;
    logic              awlock;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awprot, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awprot, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_write_burst_multi.sv
// Multi-burst AXI4 write master: streams BRAM words to memory in INCR bursts split on length/4 KB.
// Optional AXI_WRITE_BURST_ABORT_EN: an error response ends the run immediately.
module axi_write_burst_multi #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_MAX_BURST_LEN    = 16,
    parameter int unsigned C_LEN_WIDTH        = 16,
    parameter int unsigned C_BRAM_ADDR_WIDTH  = 10
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_areset,
    axi_write_burst_multi_if.master         m_axi,
    input  logic                            run,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   start_addr,
    input  logic [C_LEN_WIDTH-1:0]          byte_length,
    output logic                            bram_read_enable,
    output logic [C_BRAM_ADDR_WIDTH-1:0]    bram_read_index,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   bram_read_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);
    localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned SZ    = $clog2(BYTES);
    localparam int unsigned NW    = C_LEN_WIDTH + 1;
    localparam int unsigned CW    = (NW > 13) ? NW : 13;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t           state, state_d;
    logic [NW-1:0]    n_beats_c, rem_aw, rd_left, run_left, run_left_d, src_rem_c;
    logic [BYTES-1:0] tail_c, tail_strb, tail_d;
    logic [AW-1:0]    aligned_c, next_addr, src_addr_c;
    logic [8:0]       len_c, burst_left, burst_left_d;
    logic [1:0]       occ, occ_d;
    logic             rv;
    logic [DW-1:0]    slot1;
    logic             accept_c, aw_hs_c, pop_c, b_hs_c, abort_c, active_c, wvalid_d;

    // Beats allowed by remaining count, max burst length and distance to the next 4 KB page.
    function automatic logic [8:0] burst_len(input logic [11:0] a, input logic [NW-1:0] rem);
        logic [CW-1:0] room;
        logic [CW-1:0] lim;
        room = CW'((13'd4096 - {1'b0, a}) >> SZ);
        lim  = CW'(C_MAX_BURST_LEN);
        if (CW'(rem) < lim) lim = CW'(rem);
        if (room < lim) lim = room;
        return 9'(lim);
    endfunction

    assign m_axi.awsize  = 3'(SZ);
    assign m_axi.awburst = 2'b01;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awlock  = 1'b0;

    assign n_beats_c = (NW'(byte_length) + NW'(BYTES - 1)) >> SZ;
    assign tail_c    = (byte_length[SZ-1:0] == '0) ? '1 : ~({BYTES{1'b1}} << byte_length[SZ-1:0]);
    assign aligned_c = start_addr & ~AW'(BYTES - 1);

    assign accept_c = (state == S_IDLE) && run && (n_beats_c != '0);
    assign aw_hs_c  = (state == S_ADDR) && m_axi.awready;
    assign pop_c    = m_axi.wvalid && m_axi.wready;
    assign b_hs_c   = (state == S_RESP) && m_axi.bvalid;
    assign active_c = (state == S_ADDR) || (state == S_DATA) || (state == S_RESP);

`ifdef AXI_WRITE_BURST_ABORT_EN
    assign abort_c = (m_axi.bresp != 2'b00);
`else
    assign abort_c = 1'b0;
`endif

    // Read only while the buffer plus the word in flight, net of this cycle's pop, has room.
    assign bram_read_enable = active_c && (rd_left != '0) &&
                              ((3'(occ) + 3'(rv) - 3'(pop_c)) < 3'd2);

    assign src_addr_c   = (state == S_IDLE) ? aligned_c : next_addr;
    assign src_rem_c    = (state == S_IDLE) ? n_beats_c : rem_aw;
    assign len_c        = burst_len(src_addr_c[11:0], src_rem_c);
    assign occ_d        = occ + 2'(rv) - 2'(pop_c);
    assign wvalid_d     = (state_d == S_DATA) && (occ_d != 2'd0);
    assign burst_left_d = aw_hs_c ? (9'(m_axi.awlen) + 9'd1) :
                          (pop_c ? burst_left - 9'd1 : burst_left);
    assign run_left_d   = accept_c ? n_beats_c : (pop_c ? run_left - NW'(1) : run_left);
    assign tail_d       = accept_c ? tail_c : tail_strb;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) state <= S_IDLE;
        else              state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (run) state_d = (n_beats_c == '0) ? S_DONE : S_ADDR;
            S_ADDR:  if (m_axi.awready) state_d = S_DATA;
            S_DATA:  if (pop_c && m_axi.wlast) state_d = S_RESP;
            S_RESP:  if (m_axi.bvalid) state_d = (abort_c || rem_aw == '0) ? S_DONE : S_ADDR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            m_axi.awaddr    <= '0;
            m_axi.awlen     <= '0;
            m_axi.awvalid   <= 1'b0;
            m_axi.wdata     <= '0;
            m_axi.wstrb     <= '0;
            m_axi.wlast     <= 1'b0;
            m_axi.wvalid    <= 1'b0;
            m_axi.bready    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            bram_read_index <= '0;
            rem_aw          <= '0;
            rd_left         <= '0;
            run_left        <= '0;
            next_addr       <= '0;
            burst_left      <= '0;
            tail_strb       <= '0;
            occ             <= '0;
            rv              <= 1'b0;
            slot1           <= '0;
        end else begin
            m_axi.awvalid <= (state_d == S_ADDR);
            m_axi.bready  <= (state_d == S_RESP);
            done          <= (state_d == S_DONE);
            busy          <= (state_d == S_ADDR) || (state_d == S_DATA) || (state_d == S_RESP);
            m_axi.wvalid  <= wvalid_d;
            m_axi.wlast   <= wvalid_d && (burst_left_d == 9'd1);
            m_axi.wstrb   <= wvalid_d ? ((run_left_d == NW'(1)) ? tail_d : '1) : '0;
            burst_left    <= burst_left_d;
            run_left      <= run_left_d;
            tail_strb     <= tail_d;
            rv            <= bram_read_enable;

            if ((state_d == S_ADDR) && (state != S_ADDR)) begin
                m_axi.awaddr <= src_addr_c;
                m_axi.awlen  <= 8'(len_c - 9'd1);
            end
            if (accept_c) begin
                rem_aw <= n_beats_c;
                error  <= 1'b0;
            end else if (aw_hs_c) begin
                rem_aw    <= rem_aw - NW'(m_axi.awlen) - NW'(1);
                next_addr <= m_axi.awaddr + ((AW'(m_axi.awlen) + AW'(1)) << SZ);
            end
            if (b_hs_c) error <= error | (m_axi.bresp != 2'b00);

            if (accept_c) begin
                rd_left         <= n_beats_c;
                bram_read_index <= '0;
            end else if (bram_read_enable) begin
                rd_left         <= rd_left - NW'(1);
                bram_read_index <= bram_read_index + C_BRAM_ADDR_WIDTH'(1);
            end

            // Two-slot buffer: the W output register is the head, slot1 the spill entry.
            if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
                occ <= '0;
            end else begin
                occ <= occ_d;
                if (pop_c) begin
                    if (occ == 2'd2) begin
                        m_axi.wdata <= slot1;
                        if (rv) slot1 <= bram_read_data;
                    end else if (rv) begin
                        m_axi.wdata <= bram_read_data;
                    end
                end else if (rv) begin
                    if (occ == 2'd0) m_axi.wdata <= bram_read_data;
                    else             slot1       <= bram_read_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_write_burst_multi.sv
// Directed bench for axi_write_burst_multi: AXI slave/BRAM models plus hand-computed expectations.
module tb_axi_write_burst_multi;
    localparam int unsigned AW = 32, DW = 64, LW = 16, BW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, run, bram_read_enable, busy, done, error;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] byte_length;
    logic [BW-1:0] bram_read_index;
    logic [DW-1:0] bram_read_data;

    axi_write_burst_multi_if #(.ADDR_W(AW), .DATA_W(DW)) m_axi ();

    axi_write_burst_multi #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_MAX_BURST_LEN(16),
        .C_LEN_WIDTH(LW), .C_BRAM_ADDR_WIDTH(BW)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst), .m_axi(m_axi),
        .run(run), .start_addr(start_addr), .byte_length(byte_length),
        .bram_read_enable(bram_read_enable), .bram_read_index(bram_read_index),
        .bram_read_data(bram_read_data), .busy(busy), .done(done), .error(error)
    );

    int checks = 0, failures = 0;
    int done_cnt, busy_seen, pend_b, w_allow, aw_open;
    bit stall = 0, prev_wstall = 0, prev_awstall = 0;
    logic [72:0] prev_w;
    logic [39:0] prev_aw;
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [63:0] w_data_q[$];
    logic [7:0]  w_strb_q[$];
    logic [1:0]  bresp_q[$];

    function automatic logic [63:0] word(input int k);
        return {16'hC0DE, 16'(k), 32'(k) ^ 32'h5A5A_0000};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) if (bram_read_enable) bram_read_data <= word(int'(bram_read_index));

    // AXI slave: drives readies/B at negedge and records the handshakes of the coming posedge.
    initial begin
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 0;
        pend_b = 0; w_allow = 0; aw_open = 0; done_cnt = 0; busy_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0;
                pend_b = 0; w_allow = 0; aw_open = 0; prev_wstall = 0; prev_awstall = 0;
                continue;
            end
            if (prev_wstall)
                check("w_stable", {m_axi.wvalid, m_axi.wdata, m_axi.wstrb, m_axi.wlast}, {1'b1, prev_w});
            if (prev_awstall)
                check("aw_stable", {m_axi.awvalid, m_axi.awaddr, m_axi.awlen}, {1'b1, prev_aw});
            m_axi.awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi.wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi.bvalid  = (pend_b > 0) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            m_axi.bresp   = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
            if (m_axi.awvalid && m_axi.awready) begin
                check("aw_after_b", 32'(aw_open), 32'd0);
                aw_addr_q.push_back(m_axi.awaddr);
                aw_len_q.push_back(m_axi.awlen);
                aw_open = 1;
                w_allow += int'(m_axi.awlen) + 1;
            end
            if (m_axi.wvalid && m_axi.wready) begin
                check("w_after_aw", 1'(w_allow > 0), 1'b1);
                check("wlast_pos", m_axi.wlast, 1'(w_allow == 1));
                w_data_q.push_back(m_axi.wdata);
                w_strb_q.push_back(m_axi.wstrb);
                if (w_allow > 0) w_allow--;
                if (m_axi.wlast) pend_b++;
            end
            if (m_axi.bvalid && m_axi.bready) begin
                pend_b--;
                aw_open = 0;
                if (bresp_q.size() > 0) void'(bresp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 1'b0);
            end
            if (busy) busy_seen = 1;
            prev_wstall  = m_axi.wvalid && !m_axi.wready;
            prev_w       = {m_axi.wdata, m_axi.wstrb, m_axi.wlast};
            prev_awstall = m_axi.awvalid && !m_axi.awready;
            prev_aw      = {m_axi.awaddr, m_axi.awlen};
        end
    end

    task automatic start_run(input logic [31:0] a, input logic [15:0] len);
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_strb_q.delete();
        done_cnt = 0; busy_seen = 0;
        @(negedge clk);
        start_addr = a; byte_length = len; run = 1;
        @(negedge clk);
        run = 0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt != 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check(tag, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; run = 0; start_addr = 0; byte_length = 0;
        repeat (3) @(negedge clk);
        check("rst_awvalid", m_axi.awvalid, 1'b0);
        check("rst_wvalid", m_axi.wvalid, 1'b0);
        check("rst_bready", m_axi.bready, 1'b0);
        check("rst_awsize", m_axi.awsize, 3'd3);
        check("rst_awburst", m_axi.awburst, 2'b01);
        check("rst_flags", {busy, done, error, bram_read_enable}, 4'b0000);
        check("rst_awaddr", m_axi.awaddr, 32'd0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Single 8-beat burst.
        start_run(32'h1000, 16'd64);
        wait_done("t1_done");
        check("t1_aw_cnt", 32'(aw_addr_q.size()), 32'd1);
        check("t1_awaddr", aw_addr_q[0], 32'h1000);
        check("t1_awlen", aw_len_q[0], 8'd7);
        check("t1_w_cnt", 32'(w_data_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("t1_wdata%0d", i), w_data_q[i], word(i));
        check("t1_wstrb7", w_strb_q[7], 8'hFF);
        check("t1_busy_seen", 32'(busy_seen), 32'd1);
        check("t1_error", error, 1'b0);

        // Tail strobe; a second run pulse while busy is ignored.
        start_run(32'h2000, 16'd20);
        @(negedge clk);
        start_addr = 32'h7000; byte_length = 16'd8; run = 1;
        @(negedge clk);
        run = 0;
        wait_done("t2_done");
        check("t2_aw_cnt", 32'(aw_addr_q.size()), 32'd1);
        check("t2_awaddr", aw_addr_q[0], 32'h2000);
        check("t2_awlen", aw_len_q[0], 8'd2);
        check("t2_strbs", {w_strb_q[0], w_strb_q[1], w_strb_q[2]}, 24'hFFFF0F);

        // Zero-length run: done only.
        start_run(32'h2000, 16'd0);
        wait_done("t3_done");
        check("t3_aw_cnt", 32'(aw_addr_q.size()), 32'd0);
        check("t3_busy_seen", 32'(busy_seen), 32'd0);

        // 4 KB boundary split.
        start_run(32'h0FC0, 16'd256);
        wait_done("t4_done");
        check("t4_aw_cnt", 32'(aw_addr_q.size()), 32'd3);
        check("t4_aw0", {aw_addr_q[0], aw_len_q[0]}, {32'h0FC0, 8'd7});
        check("t4_aw1", {aw_addr_q[1], aw_len_q[1]}, {32'h1000, 8'd15});
        check("t4_aw2", {aw_addr_q[2], aw_len_q[2]}, {32'h1080, 8'd7});
        for (int i = 0; i < 32; i++) check($sformatf("t4_wdata%0d", i), w_data_q[i], word(i));

        // Random stalls on a 100-beat run.
        stall = 1;
        start_run(32'h3000, 16'd800);
        wait_done("t5_done");
        stall = 0;
        check("t5_aw_cnt", 32'(aw_addr_q.size()), 32'd7);
        check("t5_aw6", {aw_addr_q[6], aw_len_q[6]}, {32'h3300, 8'd3});
        check("t5_w_cnt", 32'(w_data_q.size()), 32'd100);
        for (int i = 0; i < 100; i++) check($sformatf("t5_wdata%0d", i), w_data_q[i], word(i));

        // Error response on the first of three bursts.
        bresp_q.delete();
        bresp_q.push_back(2'b10); bresp_q.push_back(2'b00); bresp_q.push_back(2'b00);
        start_run(32'h4000, 16'd384);
        wait_done("t6_done");
        check("t6_error", error, 1'b1);
`ifdef AXI_WRITE_BURST_ABORT_EN
        check("t6_aw_cnt", 32'(aw_addr_q.size()), 32'd1);
        check("t6_w_cnt", 32'(w_data_q.size()), 32'd16);
`else
        check("t6_aw_cnt", 32'(aw_addr_q.size()), 32'd3);
        check("t6_w_cnt", 32'(w_data_q.size()), 32'd48);
`endif
        bresp_q.delete();

        // Next run clears the sticky error on accept.
        start_run(32'h5000, 16'd8);
        check("t7_error_clear", error, 1'b0);
        wait_done("t7_done");
        check("t7_aw", {aw_addr_q[0], aw_len_q[0]}, {32'h5000, 8'd0});
        check("t7_wdata0", w_data_q[0], word(0));

        // Reset in the middle of DATA, then a clean run.
        start_run(32'h6000, 16'd128);
        for (int i = 0; i < 200; i++) begin
            if (w_data_q.size() >= 3) break;
            @(negedge clk);
        end
        check("t8_in_data", 1'(w_data_q.size() >= 3), 1'b1);
        rst = 1;
        @(negedge clk);
        check("t8_rst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.wlast, m_axi.bready}, 4'b0000);
        check("t8_rst_flags", {busy, done, error, bram_read_enable}, 4'b0000);
        check("t8_rst_wpath", {m_axi.wdata, m_axi.wstrb}, 72'd0);
        check("t8_rst_aw", {m_axi.awaddr, m_axi.awlen, bram_read_index}, 50'd0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        start_run(32'h6000, 16'd16);
        wait_done("t8_done");
        check("t8_aw", {aw_addr_q[0], aw_len_q[0]}, {32'h6000, 8'd1});
        check("t8_w_cnt", 32'(w_data_q.size()), 32'd2);
        check("t8_wdata", {w_data_q[0], w_data_q[1]}, {word(0), word(1)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
